sync_fifo_wm: RTL and testbench

Single-clock, parametrised FIFO for the stream (val/rdy) fabric. It extends the existing FIFO in several ways:
- arbitrary (non-power-of-two) depth
- exposed occupancy count
- programmable almost-full / almost-empty watermarks
- synchronous flush
It sits between same-clock producers and consumers (e.g. DSP stage to serializer) where an async FIFO is unnecessary.

---
 rtl/sync_fifo_wm.sv | 83 ++++++++
 tb/tb_sync_fifo_wm.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wm.sv
// sync_fifo_wm: single-clock val/rdy FIFO with arbitrary depth, occupancy
// count, almost-full/almost-empty watermarks and synchronous flush.
// Optional: define SYNC_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module sync_fifo_wm #(
  parameter int p_num_entries   = 8,
  parameter int p_bit_width     = 8,
  parameter int p_afull_thresh  = 6,
  parameter int p_aempty_thresh = 1,
  localparam int CW = $clog2(p_num_entries + 1),
  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   flush,
  input  logic [p_bit_width-1:0] istream_msg,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  output logic [p_bit_width-1:0] ostream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [CW-1:0]          count,
  output logic                   almost_full,
  output logic                   almost_empty
);

  logic [p_bit_width-1:0] mem [p_num_entries];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic                   full, empty, push, pop;

  assign full  = (count == CW'(p_num_entries));
  assign empty = (count == '0);

  // Ready depends only on registered occupancy, never on ostream_rdy;
  // held low while reset is applied.
  assign istream_rdy = !full && !flush && !async_rst;

`ifdef SYNC_FIFO_BYPASS_EN
  logic bypass;
  // Empty queue with incoming data: present it straight at the output.
  assign bypass      = empty && istream_val && !flush && !async_rst;
  assign ostream_val = (!empty || bypass) && !flush;
  assign ostream_msg = empty ? istream_msg : mem[rd_ptr];
  // A bypassed word consumed this cycle is never stored.
  assign push        = istream_val && istream_rdy && !(bypass && ostream_rdy);
`else
  assign ostream_val = !empty && !flush;
  assign ostream_msg = mem[rd_ptr];
  assign push        = istream_val && istream_rdy;
`endif

  // Only stored words are popped; a bypassed word never touches rd_ptr.
  assign pop = ostream_val && ostream_rdy && !empty;

  assign almost_full  = (count >= CW'(p_afull_thresh));
  assign almost_empty = (count <= CW'(p_aempty_thresh));

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= istream_msg;
  end

  // Pointers and occupancy; explicit wrap so any depth works.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(p_num_entries - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(p_num_entries - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Self-checking bench for sync_fifo_wm (depth 5, afull 4, aempty 1).
// Reference is a plain queue; expected outputs derive from its size/head.
module tb_sync_fifo_wm;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          async_rst, flush, istream_val, istream_rdy, ostream_val, ostream_rdy;
  logic [W-1:0]  istream_msg, ostream_msg;
  logic [CW-1:0] count;
  logic          almost_full, almost_empty;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[$];

`ifdef SYNC_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  sync_fifo_wm #(.p_num_entries(N), .p_bit_width(W),
                 .p_afull_thresh(AF), .p_aempty_thresh(AE)) dut (
    .clk(clk), .async_rst(async_rst), .flush(flush),
    .istream_msg(istream_msg), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .ostream_msg(ostream_msg), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare every output against what the queue says should be visible now.
  task automatic check_outputs(input string ph);
    bit exp_rdy, exp_val;
    exp_rdy = !async_rst && (q.size() < N) && !flush;
    exp_val = !async_rst && !flush && (q.size() > 0 || (BYP && istream_val));
    chk({ph, ":count"}, 32'(count), 32'(q.size()));
    chk({ph, ":irdy"},  32'(istream_rdy), 32'(exp_rdy));
    chk({ph, ":oval"},  32'(ostream_val), 32'(exp_val));
    chk({ph, ":afull"}, 32'(almost_full), 32'(q.size() >= AF));
    chk({ph, ":aempty"}, 32'(almost_empty), 32'(q.size() <= AE));
    if (exp_val)
      chk({ph, ":omsg"}, 32'(ostream_msg), 32'(q.size() > 0 ? q[0] : istream_msg));
  endtask

  // One clock: drive, check, advance reference, take the edge.
  task automatic cyc(input string ph, input bit v, input logic [W-1:0] m,
                     input bit r, input bit f);
    bit has_room, do_pop, do_push;
    istream_val = v; istream_msg = m; ostream_rdy = r; flush = f;
    #2;
    check_outputs(ph);
    if (f) q.delete();
    else begin
      has_room = q.size() < N;
      do_push  = v && has_room;
      do_pop   = r && (q.size() > 0 || (BYP && v));
      if (BYP && q.size() == 0 && v && r) begin
        // passes straight through, never stored
      end else begin
        if (do_pop && q.size() > 0) void'(q.pop_front());
        if (do_push) q.push_back(m);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    async_rst = 1'b1; flush = 0; istream_val = 0; istream_msg = '0; ostream_rdy = 0;
    #2;
    check_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    async_rst = 1'b0;

    // Fill: 0x11..0x15 with consumer stalled
    for (int i = 0; i < N; i++) cyc("fill", 1, W'(8'h11 + i), 0, 0);
    cyc("full_hold", 1, 8'hEE, 0, 0);
    // Full plus pop: pop happens, push refused
    cyc("full_pop", 1, 8'hEF, 1, 0);
    chk("full_pop:count4", 32'(count), 32'd4);
    // Drain
    for (int i = 0; i < 4; i++) cyc("drain", 0, 8'h00, 1, 0);
    // Wrap: push 3, pop 3, then 0xA0..0xA4, pop all
    for (int i = 0; i < 3; i++) cyc("wrap_push", 1, W'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) cyc("wrap_pop", 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) cyc("wrap_fill", 1, W'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("wrap_order", 32'(ostream_msg), 32'(8'hA0 + i));
      cyc("wrap_drain", 0, 8'h00, 1, 0);
    end
    chk("wrap_empty", 32'(count), 32'd0);

    // Simultaneous push/pop at count=2
    cyc("pp_pre", 1, 8'h30, 0, 0);
    cyc("pp_pre", 1, 8'h31, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("pp_delay2", 32'(ostream_msg), 32'(8'h30 + i));
      cyc("pp", 1, W'(8'h32 + i), 1, 0);
      chk("pp_count", 32'(count), 32'd2);
    end
    cyc("pp_post", 0, 8'h00, 1, 0);
    cyc("pp_post", 1, 8'h77, 1, 0);

    // Flush at count=3 alongside push and pop requests
    cyc("fl_pre", 1, 8'h40, 0, 0);
    cyc("fl_pre", 1, 8'h41, 0, 0);
    chk("fl_count3", 32'(count), 32'd3);
    cyc("flush", 1, 8'h42, 1, 1);
    chk("flush:count0", 32'(count), 32'd0);
    cyc("post_flush", 0, 8'h00, 0, 0);

    // Async reset mid-cycle at count=3
    for (int i = 0; i < 3; i++) cyc("ar_pre", 1, W'($urandom), 0, 0);
    istream_val = 1; ostream_rdy = 0; flush = 0;
    #2;
    async_rst = 1'b1;
    q.delete();
    #1;
    check_outputs("async_rst");
    @(posedge clk); #1;
    async_rst = 1'b0;
    istream_val = 0;
    #1;
    check_outputs("rst_release");
    @(posedge clk); #1;
    cyc("first_5a", 1, 8'h5A, 0, 0);
    chk("first_5a:val", 32'(ostream_val), 32'd1);
    chk("first_5a:msg", 32'(ostream_msg), 32'h5A);
    cyc("first_5a_pop", 0, 8'h00, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 300; i++)
      cyc("rand", 1'($urandom), W'($urandom), 1'($urandom),
          ($urandom_range(0, 29) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
